// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port instruction/data memory between
// the CPU port (c_*) and the debug/loader port (d_*). Accesses are serialised
// by a three-state FSM (IDLE -> ACCESS [-> RDATA]). The FSM absorbs the
// memory's one-cycle read latency and returns registered read data together
// with a one-cycle valid pulse.
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants on contention;
// otherwise the CPU wins ties, bounded by the MAX_BURST starvation guard.
module mem_port_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  output logic [DW-1:0] c_rdata,
  output logic          c_rvalid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_rvalid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RDATA  = 2'd2
  } state_t;

  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  state_t     state;
  state_t     state_nx;
  logic       cap_we;
  logic       last_owner;
  logic [3:0] burst_cnt;
  logic       any_req;
  logic       winner;

  assign any_req = c_req | d_req;

  // Winner selection: a lone requester wins; on contention the starvation
  // guard (burst limit reached) hands the grant to the other port first.
  always_comb begin
    winner = 1'b0;
    if (c_req && d_req) begin
      if (burst_cnt == BURST_LIM) begin
        winner = ~last_owner;
      end else begin
`ifdef ARB_ROUND_ROBIN_EN
        winner = ~last_owner;
`else
        winner = 1'b0;
`endif
      end
    end else if (d_req) begin
      winner = 1'b1;
    end
  end

  // Next-state logic and decoded outputs.
  always_comb begin
    state_nx = state;
    mem_we   = 1'b0;
    c_ack    = 1'b0;
    d_ack    = 1'b0;
    busy     = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (any_req) state_nx = S_ACCESS;
      end
      S_ACCESS: begin
        mem_we   = cap_we;
        c_ack    = ~owner;
        d_ack    = owner;
        state_nx = cap_we ? S_IDLE : S_RDATA;
      end
      S_RDATA: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Grant capture, burst accounting, and read-data return.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      burst_cnt  <= '0;
      c_rdata    <= '0;
      d_rdata    <= '0;
      c_rvalid   <= 1'b0;
      d_rvalid   <= 1'b0;
    end else begin
      c_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            cap_we     <= winner ? d_we    : c_we;
            mem_addr   <= winner ? d_addr  : c_addr;
            mem_din    <= winner ? d_wdata : c_wdata;
            owner      <= winner;
            last_owner <= winner;
            if (winner == last_owner) begin
              if (burst_cnt != 4'd15) burst_cnt <= burst_cnt + 4'd1;
            end else begin
              burst_cnt <= 4'd1;
            end
          end else begin
            burst_cnt <= '0;
          end
        end
        S_RDATA: begin
          if (owner) begin
            d_rdata  <= mem_dout;
            d_rvalid <= 1'b1;
          end else begin
            c_rdata  <= mem_dout;
            c_rvalid <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter. The memory is modelled
// as a synchronous-read array with one-cycle latency whose contents are a
// fixed function of the address.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          c_req, c_we, d_req, d_we;
  logic [AW-1:0] c_addr, d_addr;
  logic [DW-1:0] c_wdata, d_wdata;
  logic          c_ack, d_ack, c_rvalid, d_rvalid;
  logic [DW-1:0] c_rdata, d_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic          busy, owner;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_rdata(c_rdata), .c_rvalid(c_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return 32'hC0DE_0000 ^ a;
  endfunction

  // One-cycle-latency memory read model.
  always @(posedge clk) mem_dout <= mem_val(mem_addr);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " c_ack"}, 64'(c_ack), 64'd0);
    check({tag, " d_ack"}, 64'(d_ack), 64'd0);
    check({tag, " c_rvalid"}, 64'(c_rvalid), 64'd0);
    check({tag, " d_rvalid"}, 64'(d_rvalid), 64'd0);
    check({tag, " c_rdata"}, 64'(c_rdata), 64'd0);
    check({tag, " d_rdata"}, 64'(d_rdata), 64'd0);
    check({tag, " mem_we"}, 64'(mem_we), 64'd0);
    check({tag, " mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, " mem_din"}, 64'(mem_din), 64'd0);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " owner"}, 64'(owner), 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b1;

    // CPU read of 0x10: ack at N+1, rvalid at N+3.
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
    tick();
    check("rd ack", 64'(c_ack), 64'd1);
    check("rd d_ack", 64'(d_ack), 64'd0);
    check("rd mem_addr", 64'(mem_addr), 64'h10);
    check("rd mem_we", 64'(mem_we), 64'd0);
    check("rd busy", 64'(busy), 64'd1);
    check("rd owner", 64'(owner), 64'd0);
    c_req = 1'b0;
    tick();
    check("rd N+2 ack", 64'(c_ack), 64'd0);
    check("rd N+2 rvalid", 64'(c_rvalid), 64'd0);
    check("rd N+2 busy", 64'(busy), 64'd1);
    tick();
    check("rd rvalid", 64'(c_rvalid), 64'd1);
    check("rd rdata", 64'(c_rdata), 64'hDEADBEEF);
    check("rd d_rvalid", 64'(d_rvalid), 64'd0);
    check("rd d_rdata", 64'(d_rdata), 64'd0);
    check("rd N+3 busy", 64'(busy), 64'd0);
    tick();
    check("rd N+4 rvalid", 64'(c_rvalid), 64'd0);
    check("rd hold rdata", 64'(c_rdata), 64'hDEADBEEF);

    // Debug write.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678;
    tick();
    check("wr mem_we", 64'(mem_we), 64'd1);
    check("wr mem_addr", 64'(mem_addr), 64'h20);
    check("wr mem_din", 64'(mem_din), 64'h12345678);
    check("wr d_ack", 64'(d_ack), 64'd1);
    check("wr c_ack", 64'(c_ack), 64'd0);
    check("wr owner", 64'(owner), 64'd1);
    d_req = 1'b0;
    tick();
    check("wr N+2 mem_we", 64'(mem_we), 64'd0);
    check("wr N+2 busy", 64'(busy), 64'd0);
    check("wr N+2 d_rvalid", 64'(d_rvalid), 64'd0);
    check("wr c_rdata kept", 64'(c_rdata), 64'hDEADBEEF);
    tick();

`ifdef ARB_ROUND_ROBIN_EN
    // Contending reads alternate C,D,C,D starting with the CPU.
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    for (int g = 0; g < 4; g++) begin
      tick();
      check("rr c_ack", 64'(c_ack), 64'(g % 2 == 0));
      check("rr d_ack", 64'(d_ack), 64'(g % 2 == 1));
      check("rr owner", 64'(owner), 64'(g % 2 == 1));
      tick();
      tick();
      check("rr c_rvalid", 64'(c_rvalid), 64'(g % 2 == 0));
      check("rr d_rvalid", 64'(d_rvalid), 64'(g % 2 == 1));
    end
    c_req = 1'b0; d_req = 1'b0;
    check("rr d_rdata", 64'(d_rdata), 64'(mem_val(32'h20)));
`else
    // Contending writes: C,C,C,C,D repeating under MAX_BURST=4.
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h40; c_wdata = 32'hAAAA0001;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hBBBB0002;
    for (int g = 0; g < 10; g++) begin
      tick();
      check("fp c_ack", 64'(c_ack), 64'(g % 5 != 4));
      check("fp d_ack", 64'(d_ack), 64'(g % 5 == 4));
      check("fp mem_addr", 64'(mem_addr), (g % 5 == 4) ? 64'h80 : 64'h40);
      tick();
    end
    c_req = 1'b0; d_req = 1'b0;
`endif
    tick();

    // Reset asserted while a CPU read sits in RDATA.
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h30;
    tick();
    check("rst ack", 64'(c_ack), 64'd1);
    c_req = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check_all_zero("async rst");
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post-rst c_rvalid", 64'(c_rvalid), 64'd0);
    end

    // CPU req held across ack: two back-to-back reads at 0x0 and 0x4.
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h0;
    tick();
    check("held ack1", 64'(c_ack), 64'd1);
    check("held addr1", 64'(mem_addr), 64'h0);
    c_addr = 32'h4;
    tick();
    tick();
    check("held rvalid1", 64'(c_rvalid), 64'd1);
    check("held rdata1", 64'(c_rdata), 64'(mem_val(32'h0)));
    tick();
    check("held ack2", 64'(c_ack), 64'd1);
    check("held addr2", 64'(mem_addr), 64'h4);
    c_req = 1'b0;
    tick();
    check("held gap rvalid", 64'(c_rvalid), 64'd0);
    tick();
    check("held rvalid2", 64'(c_rvalid), 64'd1);
    check("held rdata2", 64'(c_rdata), 64'(mem_val(32'h4)));
    check("held d_rdata", 64'(d_rdata), 64'd0);
    check("held d_rvalid", 64'(d_rvalid), 64'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global invariants: never both acks or both rvalids together.
  always @(negedge clk) begin
    if (rst) begin
      check("dual ack", 64'(c_ack & d_ack), 64'd0);
      check("dual rvalid", 64'(c_rvalid & d_rvalid), 64'd0);
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
